imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the ID-stage immediate generator.
- Extracts and extends immediates for all RV formats (U, J, I, B, S, shamt, CSR zimm) at configurable XLEN.
- Output is registered behind a valid/ready handshake with stall and flush support, so it drops directly into the ID/EX pipeline register path.
- Tracks illegal format selects in a saturating counter for debug.

---
 rtl/imm_gen_pipe.sv | 144 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with valid/ready output, stall/flush and illegal-select counter.
// Optional: define IMM_GEN_OPCODE_DECODE_EN to derive the format from the opcode instead of SELECT[2:0].
module imm_gen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTRUCTION,
  input  logic [3:0]       SELECT,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] ILLEGAL_COUNT
);

  localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;
  localparam int unsigned LAST    = LATENCY - 1;

  localparam logic [2:0] FMT_U     = 3'b000;
  localparam logic [2:0] FMT_J     = 3'b001;
  localparam logic [2:0] FMT_I     = 3'b010;
  localparam logic [2:0] FMT_B     = 3'b011;
  localparam logic [2:0] FMT_S     = 3'b100;
  localparam logic [2:0] FMT_SHAMT = 3'b101;
  localparam logic [2:0] FMT_ZIMM  = 3'b110;
  localparam logic [2:0] FMT_ILL   = 3'b111;

  logic [2:0]      fmt_c;
  logic            unused_c;
  logic            sgn_c;
  logic [31:0]     v32_c;
  logic            ill_c;
  logic [XLEN-1:0] imm_c;
  logic            adv_c;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] ill_q, ill_d;
  logic [XLEN-1:0]    imm_q [LATENCY];
  logic [XLEN-1:0]    imm_d [LATENCY];
  logic [CNT_W-1:0]   cnt_q, cnt_d;

`ifdef IMM_GEN_OPCODE_DECODE_EN
  // Format from the major opcode; SELECT[3] still requests zero extension.
  always_comb begin
    fmt_c = FMT_ILL;
    case (INSTRUCTION[6:0])
      7'b0110111, 7'b0010111: fmt_c = FMT_U;
      7'b1101111:             fmt_c = FMT_J;
      7'b1100111, 7'b0000011: fmt_c = FMT_I;
      7'b0010011:             fmt_c = (INSTRUCTION[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
      7'b1100011:             fmt_c = FMT_B;
      7'b0100011:             fmt_c = FMT_S;
      7'b1110011:             fmt_c = INSTRUCTION[14] ? FMT_ZIMM : FMT_ILL;
      default:                fmt_c = FMT_ILL;
    endcase
  end
  assign unused_c = ^SELECT[2:0];
`else
  assign fmt_c    = SELECT[2:0];
  assign unused_c = ^INSTRUCTION[6:0];
`endif

  // Immediate extraction; v32_c is already extended to 32 bits, bit 31 drives the XLEN extension.
  always_comb begin
    sgn_c = ~SELECT[3] & INSTRUCTION[31];
    v32_c = '0;
    ill_c = 1'b0;
    case (fmt_c)
      FMT_U: v32_c = {INSTRUCTION[31:12], 12'b0};
      FMT_J: v32_c = {{11{sgn_c}}, INSTRUCTION[31], INSTRUCTION[19:12],
                      INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
      FMT_I: v32_c = {{20{sgn_c}}, INSTRUCTION[31:20]};
      FMT_B: v32_c = {{19{sgn_c}}, INSTRUCTION[31], INSTRUCTION[7],
                      INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
      FMT_S: v32_c = {{20{sgn_c}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
      FMT_SHAMT: v32_c = 32'(INSTRUCTION[20 +: SHAMT_W]);
      FMT_ZIMM:  v32_c = 32'(INSTRUCTION[19:15]);
      default:   ill_c = 1'b1;
    endcase
    imm_c       = {XLEN{v32_c[31]}};
    imm_c[31:0] = v32_c;
  end

  assign adv_c    = OUT_READY | ~vld_q[LAST];
  assign IN_READY = adv_c;

  // Whole pipe shifts together or holds; flush kills every valid bit regardless of the stall.
  always_comb begin
    vld_d = vld_q;
    ill_d = ill_q;
    imm_d = imm_q;
    if (adv_c) begin
      vld_d[0] = IN_VALID;
      ill_d[0] = ill_c;
      imm_d[0] = imm_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_d[i] = vld_q[i-1];
        ill_d[i] = ill_q[i-1];
        imm_d[i] = imm_q[i-1];
      end
    end
    if (FLUSH) begin
      vld_d = '0;
    end
  end

  // Saturating count of illegal selects that are accepted and survive the same-cycle flush.
  always_comb begin
    cnt_d = cnt_q;
    if (IN_VALID && adv_c && !FLUSH && ill_c && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_q <= '0;
      ill_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        imm_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(LATENCY); i++) begin
        imm_q[i] <= imm_d[i];
      end
    end
  end

  assign OUT_VALID     = vld_q[LAST];
  assign OUT           = imm_q[LAST];
  assign ILLEGAL       = ill_q[LAST];
  assign ILLEGAL_COUNT = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: dut_a (XLEN=32, LATENCY=1, CNT_W=2) and dut_b (XLEN=64, LATENCY=3, CNT_W=16).
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_illegal;
  logic [31:0] a_instr, a_out;
  logic [3:0]  a_sel;
  logic [1:0]  a_cnt;

  logic        b_rst, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_illegal;
  logic [31:0] b_instr;
  logic [63:0] b_out;
  logic [3:0]  b_sel;
  logic [15:0] b_cnt;

  imm_gen_pipe #(.XLEN(32), .LATENCY(1), .CNT_W(2)) dut_a (
    .CLK(clk), .RESET(a_rst), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
    .INSTRUCTION(a_instr), .SELECT(a_sel), .FLUSH(a_flush), .OUT_VALID(a_out_valid),
    .OUT_READY(a_out_ready), .OUT(a_out), .ILLEGAL(a_illegal), .ILLEGAL_COUNT(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .LATENCY(3), .CNT_W(16)) dut_b (
    .CLK(clk), .RESET(b_rst), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
    .INSTRUCTION(b_instr), .SELECT(b_sel), .FLUSH(b_flush), .OUT_VALID(b_out_valid),
    .OUT_READY(b_out_ready), .OUT(b_out), .ILLEGAL(b_illegal), .ILLEGAL_COUNT(b_cnt)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitors: an entry is consumed when it is presented with OUT_READY high.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL a_unexpected: got 0x%0h expected no output", a_out);
      end else begin
        e = qa.pop_front();
        chk("a_out", 64'(a_out), 64'(e.imm[31:0]));
        chk("a_illegal", 64'(a_illegal), 64'(e.ill));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL b_unexpected: got 0x%0h expected no output", b_out);
      end else begin
        e = qb.pop_front();
        chk("b_out", b_out, e.imm);
        chk("b_illegal", 64'(b_illegal), 64'(e.ill));
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send_a(input logic [31:0] ins, input logic [3:0] sel, input logic fl,
                        input logic [63:0] e_imm, input logic e_ill, input logic keep);
    logic acc;
    acc = 1'b0;
    a_in_valid = 1'b1; a_instr = ins; a_sel = sel; a_flush = fl;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        acc = 1'b1;
        if (keep) qa.push_back('{imm: e_imm, ill: e_ill});
      end
      @(posedge clk);
    end
    if (!acc) begin
      n_chk++; n_err++;
      $display("FAIL a_send_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    #1 a_in_valid = 1'b0; a_flush = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] ins, input logic [3:0] sel,
                        input logic [63:0] e_imm, input logic e_ill, input logic keep);
    logic acc;
    acc = 1'b0;
    b_in_valid = 1'b1; b_instr = ins; b_sel = sel;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (b_in_ready) begin
        acc = 1'b1;
        if (keep) qb.push_back('{imm: e_imm, ill: e_ill});
      end
      @(posedge clk);
    end
    if (!acc) begin
      n_chk++; n_err++;
      $display("FAIL b_send_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    #1 b_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic seen;
    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 1'b0; a_instr = '0; a_sel = '0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_instr = '0; b_sel = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out", 64'(a_out), 64'd0);
    chk("rst_a_illegal", 64'(a_illegal), 64'd0);
    chk("rst_a_count", 64'(a_cnt), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_out", b_out, 64'd0);
    chk("rst_b_count", 64'(b_cnt), 64'd0);
    @(posedge clk); #1;

    // XLEN=32, LATENCY=1 directed vectors
    send_a(32'hFFF00093, 4'b0010, 1'b0, 64'hFFFFFFFF, 1'b0, 1'b1);
    send_a(32'hFFF00093, 4'b1010, 1'b0, 64'h00000FFF, 1'b0, 1'b1);
    send_a(32'h12345037, 4'b0000, 1'b0, 64'h12345000, 1'b0, 1'b1);
    send_a(32'hFE000EE3, 4'b0011, 1'b0, 64'hFFFFFFFC, 1'b0, 1'b1);
    send_a(32'h01F09093, 4'b0101, 1'b0, 64'h0000001F, 1'b0, 1'b1);
    send_a(32'h03F09093, 4'b0101, 1'b0, 64'h0000001F, 1'b0, 1'b1);
    send_a(32'hFFDFF06F, 4'b0001, 1'b0, 64'hFFFFFFFC, 1'b0, 1'b1);
    send_a(32'hFFDFF06F, 4'b1001, 1'b0, 64'h001FFFFC, 1'b0, 1'b1);
    send_a(32'h00A12223, 4'b0100, 1'b0, 64'h00000004, 1'b0, 1'b1);
    send_a(32'hFE000FA3, 4'b1100, 1'b0, 64'h00000FFF, 1'b0, 1'b1);
    send_a(32'h000FD073, 4'b0110, 1'b0, 64'h0000001F, 1'b0, 1'b1);
    send_a(32'hFFFFFFFF, 4'b0111, 1'b0, 64'h00000000, 1'b1, 1'b1);

    // XLEN=64, LATENCY=3 directed vectors
    send_b(32'h12345037, 4'b0000, 64'h0000000012345000, 1'b0, 1'b1);
    send_b(32'h80000037, 4'b0000, 64'hFFFFFFFF80000000, 1'b0, 1'b1);
    send_b(32'h80000037, 4'b1000, 64'hFFFFFFFF80000000, 1'b0, 1'b1);
    send_b(32'hFFF00093, 4'b0010, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
    send_b(32'hFFF00093, 4'b1010, 64'h0000000000000FFF, 1'b0, 1'b1);
    send_b(32'h03F09093, 4'b0101, 64'h000000000000003F, 1'b0, 1'b1);
    send_b(32'hFFDFF06F, 4'b0001, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b1);
    send_b(32'hFE000FA3, 4'b0100, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // Stream of 4 with a 2-cycle output stall after the first result
    fork
      begin
        send_b(32'h00001037, 4'b0000, 64'h0000000000001000, 1'b0, 1'b1);
        send_b(32'h00100093, 4'b0010, 64'h0000000000000001, 1'b0, 1'b1);
        send_b(32'hFE000EE3, 4'b0011, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b1);
        send_b(32'h000FD073, 4'b0110, 64'h000000000000001F, 1'b0, 1'b1);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(posedge clk); #1;
          if (b_out_valid) seen = 1'b1;
        end
        chk("b_first_out_seen", 64'(seen), 64'd1);
        b_out_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("b_stall_in_ready", 64'(b_in_ready), 64'd0);
          chk("b_stall_valid", 64'(b_out_valid), 64'd1);
          @(posedge clk);
        end
        #1 b_out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Flush with 3 entries in flight plus a coincident input
    b_out_ready = 1'b0;
    repeat (3) send_b(32'h12345037, 4'b0000, 64'h0, 1'b0, 1'b0);
    chk("b_full_valid", 64'(b_out_valid), 64'd1);
    chk("b_full_in_ready", 64'(b_in_ready), 64'd0);
    b_flush = 1'b1; b_in_valid = 1'b1; b_instr = 32'hFFF00093; b_sel = 4'b0010;
    @(posedge clk);
    #1 b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    chk("b_flush_valid", 64'(b_out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("b_post_flush_valid", 64'(b_out_valid), 64'd0);
    send_b(32'h01F09093, 4'b0101, 64'h000000000000001F, 1'b0, 1'b1);
    @(negedge clk); chk("b_fresh_s1", 64'(b_out_valid), 64'd0);
    @(negedge clk); chk("b_fresh_s2", 64'(b_out_valid), 64'd0);
    @(negedge clk); chk("b_fresh_s3", 64'(b_out_valid), 64'd1);
    @(posedge clk); #1;

    // Saturating illegal counter, CNT_W=2
    a_rst = 1'b1;
    @(posedge clk);
    #1 a_rst = 1'b0;
    chk("a_cnt_reset", 64'(a_cnt), 64'd0);
    send_a(32'h00000000, 4'b0111, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("a_cnt_1", 64'(a_cnt), 64'd1);
    send_a(32'h00000000, 4'b1111, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("a_cnt_2", 64'(a_cnt), 64'd2);
    @(posedge clk); #1;
    send_a(32'h00000000, 4'b0111, 1'b1, 64'h0, 1'b1, 1'b0);
    chk("a_cnt_flushed", 64'(a_cnt), 64'd2);
    chk("a_flushed_valid", 64'(a_out_valid), 64'd0);
    send_a(32'h00000000, 4'b0111, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("a_cnt_3", 64'(a_cnt), 64'd3);
    send_a(32'h00000000, 4'b0111, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("a_cnt_sat", 64'(a_cnt), 64'd3);
    send_a(32'h00000000, 4'b1111, 1'b0, 64'h0, 1'b1, 1'b1);
    chk("a_cnt_sat_more", 64'(a_cnt), 64'd3);
    @(posedge clk); #1;

    // Reset while an entry is held by a stall
    a_out_ready = 1'b0;
    send_a(32'hFFF00093, 4'b0010, 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("a_held_valid", 64'(a_out_valid), 64'd1);
    chk("a_held_out", 64'(a_out), 64'hFFFFFFFF);
    chk("a_held_in_ready", 64'(a_in_ready), 64'd0);
    a_rst = 1'b1;
    @(posedge clk);
    #1 a_rst = 1'b0;
    chk("a_mid_rst_valid", 64'(a_out_valid), 64'd0);
    chk("a_mid_rst_out", 64'(a_out), 64'd0);
    chk("a_mid_rst_count", 64'(a_cnt), 64'd0);
    a_out_ready = 1'b1;

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
